// File: rtl/uart_alu_pkg.sv
// Shared types and default widths for the UART <-> ALU sequencing controller.
package uart_alu_pkg;

    localparam int unsigned DEF_NB_DATA = 8;
    localparam int unsigned DEF_NB_OP   = 6;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte timeout counter: runs while i_run, clears on i_clear or when idle,
// pulses o_expire on its last count. Built only with UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (!i_run || i_clear) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A clear in the expiry cycle means a byte arrived, so it wins.
    assign o_expire = i_run && !i_clear && (count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode from the UART, runs the ALU and
// starts the transmitter. Optional inter-byte timeout: UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = DEF_NB_DATA,
    parameter int unsigned NB_OP          = DEF_NB_OP,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done_tick,
    input  logic               i_tx_done_tick,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be nonzero");
    end

    state_t state, state_next;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    logic timeout_expire;

    uart_alu_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_run   ((state == ST_WAIT_B) || (state == ST_WAIT_OP)),
        .i_clear (i_rx_done_tick),
        .o_expire(timeout_expire)
    );
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_op  <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (i_rx_done_tick) begin
                case (state)
                    ST_WAIT_A:  o_alu_a  <= i_rx_data;
                    ST_WAIT_B:  o_alu_b  <= i_rx_data;
                    ST_WAIT_OP: o_alu_op <= i_rx_data[NB_OP-1:0];
                    default:    o_overrun <= 1'b1;
                endcase
            end
            if (state == ST_EXEC) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

    always_comb begin
        state_next = state;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        case (state)
            ST_WAIT_A: begin
                if (i_rx_done_tick) state_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (i_rx_done_tick) state_next = ST_WAIT_OP;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                else if (timeout_expire) state_next = ST_WAIT_A;
`endif
            end
            ST_WAIT_OP: begin
                if (i_rx_done_tick) state_next = ST_EXEC;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
                else if (timeout_expire) state_next = ST_WAIT_A;
`endif
            end
            ST_EXEC: begin
                o_busy     = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                o_busy = 1'b1;
                if (i_tx_done_tick) state_next = ST_WAIT_A;
            end
            default: state_next = ST_WAIT_A;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with an a+b stub ALU.
// The timeout scenario runs when UART_ALU_CTRL_TIMEOUT_EN is defined.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_tick = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_result;
    logic [7:0] alu_a, alu_b, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, overrun;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_q[$];
    logic        start_d = 1'b0;

    always #5 clk = ~clk;

    assign alu_result = alu_a + alu_b;

    uart_alu_ctrl #(
        .NB_DATA(8),
        .NB_OP(6),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_done_tick(rx_tick),
        .i_tx_done_tick(tx_done),
        .i_alu_result  (alu_result),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_op      (alu_op),
        .o_tx_data     (tx_data),
        .o_tx_start    (tx_start),
        .o_busy        (busy),
        .o_overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every start pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            check("start_single", 32'(start_d), 0);
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_data_sb", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        start_d = tx_start;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    // Full A/B/opcode sequence; returns in WAIT_TX one cycle after the start pulse.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        check("alu_a", 32'(alu_a), 32'(a));
        check("busy_wait_b", 32'(busy), 0);
        send_byte(b);
        check("alu_b", 32'(alu_b), 32'(b));
        exp_q.push_back(a + b);
        send_byte(op);
        check("alu_op", 32'(alu_op), 32'(op & 8'h3F));
        check("busy_exec", 32'(busy), 1);
        check("start_n1", 32'(tx_start), 0);
        @(negedge clk);
        check("start_n2", 32'(tx_start), 1);
        @(negedge clk);
        check("start_n3", 32'(tx_start), 0);
        check("busy_wait_tx", 32'(busy), 1);
    endtask

    task automatic finish_tx();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("busy_after_done", 32'(busy), 0);
    endtask

    task automatic check_reset_state();
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        run_op(8'd85, 8'd1, 8'd32);
        check("tx_data_86", 32'(tx_data), 86);

        // Byte while in WAIT_TX is dropped and flagged
        send_byte(8'hFF);
        check("overrun_set", 32'(overrun), 1);
        check("alu_a_kept", 32'(alu_a), 85);
        check("busy_stays", 32'(busy), 1);
        check("no_restart", 32'(tx_start), 0);
        finish_tx();

        run_op(8'd5, 8'd6, 8'hE2);
        check("op_masked", 32'(alu_op), 32'h22);
        check("overrun_sticky", 32'(overrun), 1);
        finish_tx();

        // Reset mid-sequence
        send_byte(8'd9);
        send_byte(8'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd3, 8'd4, 8'h20);
        check("tx_data_7", 32'(tx_data), 7);

        // tx_done and rx tick in the same WAIT_TX cycle
        @(negedge clk);
        tx_done = 1'b1;
        rx_tick = 1'b1;
        rx_data = 8'h55;
        @(negedge clk);
        tx_done = 1'b0;
        rx_tick = 1'b0;
        check("busy_clr_sim", 32'(busy), 0);
        check("overrun_sim", 32'(overrun), 1);
        check("alu_a_no_capture", 32'(alu_a), 3);
        run_op(8'd2, 8'd2, 8'd0);
        finish_tx();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Byte landing on the expiry cycle is accepted
        send_byte(8'd40);
        repeat (98) @(negedge clk);
        send_byte(8'd2);
        check("tmo_edge_b", 32'(alu_b), 2);
        exp_q.push_back(8'd42);
        send_byte(8'd0);
        repeat (2) @(negedge clk);
        finish_tx();

        // 100 idle clocks in WAIT_B returns to WAIT_A
        send_byte(8'd7);
        repeat (100) @(negedge clk);
        run_op(8'd1, 8'd2, 8'd0);
        check("tmo_result", 32'(tx_data), 3);
        finish_tx();
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
